// File: rtl/dmem_ctrl_pkg.sv
// Shared types and lane helpers for the two-port data-memory controller.
// Covers access sizes, store lane masks and write-data replication, load extraction, and alignment checks.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } lane_t;

  // Size 2'b11 counts as misaligned so every illegal shape takes one error path.
  function automatic logic misaligned(logic [1:0] size, logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic lane_t lane_map(logic [1:0] size, logic [1:0] off, logic [31:0] wdata);
    lane_t l;
    case (size)
      SZ_BYTE: begin l.mask = 4'b0001 << off; l.data = {4{wdata[7:0]}};  end
      SZ_HALF: begin l.mask = 4'b0011 << off; l.data = {2{wdata[15:0]}}; end
      default: begin l.mask = 4'b1111;        l.data = wdata;            end
    endcase
    return l;
  endfunction

  function automatic logic [31:0] load_extract(logic [1:0] size, logic [1:0] off, logic uns,
                                               logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: load_extract = {{24{b[7] & ~uns}}, b};
      SZ_HALF: load_extract = {{16{h[15] & ~uns}}, h};
      default: load_extract = rdata;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a conflict the port not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset to port 1 so port 0 wins the first conflict.
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n)      last_grant <= 1'b1;
    else if (advance) last_grant <= grant[1];

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port arbiter and access sequencer for the single-port data memory.
// Returns one registered response per accepted request.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0]                 req_we,
  input  logic [1:0][1:0]            req_size,
  input  logic [1:0]                 req_unsigned,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                 rsp_valid,
  input  logic [1:0]                 rsp_ready,
  output logic [1:0][DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                 rsp_err,
  output logic                       mem_write_en,
  output logic [3:0]                 mem_mask,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata
);

  logic [1:0]            elig, grant;
  logic                  gnt_any, sel, err;
  logic [1:0]            sz, off;
  logic [ADDR_WIDTH-1:0] sel_addr, addr_q;
  logic [DATA_WIDTH-1:0] ld_data;
  lane_t                 lane;

  // Gating with arst_n keeps grants and write strobes dead during reset.
  assign elig = arst_n ? (req_valid & (~rsp_valid | rsp_ready)) : 2'b00;

  rr_arb2 u_arb (
    .clk     (clk),
    .arst_n  (arst_n),
    .req     (elig),
    .advance (gnt_any),
    .grant   (grant)
  );

  assign gnt_any   = |grant;
  assign sel       = grant[1];
  assign req_ready = grant;

  assign sel_addr = req_addr[sel];
  assign sz       = req_size[sel];
  assign off      = sel_addr[1:0];
  assign err      = misaligned(sz, off);
  assign lane     = lane_map(sz, off, req_wdata[sel]);

  assign mem_write_en = gnt_any & req_we[sel] & ~err;
  assign mem_mask     = (gnt_any && !err) ? lane.mask : 4'b0000;
  assign mem_wdata    = gnt_any ? lane.data : '0;
  assign mem_addr     = gnt_any ? sel_addr : addr_q;

  assign ld_data = (req_we[sel] || err) ? '0
                 : load_extract(sz, off, req_unsigned[sel], mem_rdata);

  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n)      addr_q <= '0;
    else if (gnt_any) addr_q <= sel_addr;

  // A grant wins over a drain in the same cycle, so the register reloads.
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          rsp_valid[i] <= 1'b1;
          rsp_rdata[i] <= ld_data;
          rsp_err[i]   <= err;
        end else if (rsp_ready[i] && rsp_valid[i]) begin
          rsp_valid[i] <= 1'b0;
          rsp_rdata[i] <= '0;
          rsp_err[i]   <= 1'b0;
        end
      end
    end

endmodule
